// File: rtl/mport_pkg.sv
// Shared opcodes, FSM state encoding and default widths for the mport scratchpad CFUs.
package mport_pkg;

   localparam int MPORT_ADDR_W = 14;
   localparam int MPORT_DATA_W = 32;

   localparam logic [2:0] OP_SET_PTR = 3'd0;
   localparam logic [2:0] OP_WRITE   = 3'd1;
   localparam logic [2:0] OP_FILL    = 3'd2;
   localparam logic [2:0] OP_GET_PTR = 3'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_RESP
   } state_t;

endpackage

// File: rtl/mport_we_decode.sv
// Turns the selected bank plus a write pulse into the four per-port write strobes.
// MPORT_WRITER_BROADCAST_EN: bank[2] set drives all four strobes together.
module mport_we_decode (
   input  logic [2:0] bank_i,
   input  logic       wr_i,
   output logic [3:0] we_o
);

   always_comb begin
      we_o = 4'b0000;
      if (wr_i) begin
`ifdef MPORT_WRITER_BROADCAST_EN
         we_o = bank_i[2] ? 4'b1111 : (4'b0001 << bank_i[1:0]);
`else
         we_o = 4'b0001 << bank_i[1:0];
`endif
      end
   end

endmodule

// File: rtl/mport_writer.sv
// Write-side CFU for the four-bank scratchpad: pointer setup, auto-increment writes, fill loop.
// MPORT_WRITER_BROADCAST_EN: bank[2] broadcasts writes and is reported by GET_PTR.
module mport_writer
   import mport_pkg::*;
#(
   parameter int ADDR_W = MPORT_ADDR_W,
   parameter int DATA_W = MPORT_DATA_W,
   parameter int CNT_W  = ADDR_W + 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [9:0]        cmd_payload_function_id,
   input  logic [31:0]       cmd_payload_inputs_0,
   input  logic [31:0]       cmd_payload_inputs_1,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_payload_outputs_0,
   output logic [ADDR_W-1:0] port0_addr,
   output logic [DATA_W-1:0] port0_dout,
   output logic              port0_we,
   output logic [ADDR_W-1:0] port1_addr,
   output logic [DATA_W-1:0] port1_dout,
   output logic              port1_we,
   output logic [ADDR_W-1:0] port2_addr,
   output logic [DATA_W-1:0] port2_dout,
   output logic              port2_we,
   output logic [ADDR_W-1:0] port3_addr,
   output logic [DATA_W-1:0] port3_dout,
   output logic              port3_we
);

   localparam logic [31:0] FULL_CNT = 32'(1) << ADDR_W;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [2:0]          bank_q, bank_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [31:0]         rsp_q, rsp_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   dout_q, dout_d;
   logic [3:0]          we_q, we_d;
   logic                wr;

   logic [2:0]          op;
   logic [CNT_W-1:0]    fill_cnt;
   logic [2:0]          rsp_bank;
   logic [31:0]         ptr_word;
   logic                unused_fid;

   assign op         = cmd_payload_function_id[2:0];
   assign unused_fid = ^cmd_payload_function_id[9:3];

   // Oversized counts clamp to one full pass over the bank.
   assign fill_cnt = (cmd_payload_inputs_1 > FULL_CNT) ? CNT_W'(FULL_CNT)
                                                       : cmd_payload_inputs_1[CNT_W-1:0];

`ifdef MPORT_WRITER_BROADCAST_EN
   assign rsp_bank = bank_q;
`else
   assign rsp_bank = {1'b0, bank_q[1:0]};
`endif
   assign ptr_word = 32'({rsp_bank, ptr_q});

   mport_we_decode u_we_decode (
      .bank_i (bank_q),
      .wr_i   (wr),
      .we_o   (we_d)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      bank_d  = bank_q;
      cnt_d   = cnt_q;
      rsp_d   = rsp_q;
      addr_d  = addr_q;
      dout_d  = dout_q;
      wr      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               state_d = ST_RESP;
               rsp_d   = '0;
               case (op)
                  OP_SET_PTR: begin
                     bank_d = cmd_payload_inputs_0[2:0];
                     ptr_d  = cmd_payload_inputs_1[ADDR_W-1:0];
                  end
                  OP_WRITE: begin
                     wr     = 1'b1;
                     addr_d = ptr_q;
                     dout_d = DATA_W'(cmd_payload_inputs_0);
                     ptr_d  = ptr_q + ADDR_W'(1);
                     rsp_d  = 32'(ptr_q);
                  end
                  OP_FILL: begin
                     dout_d = DATA_W'(cmd_payload_inputs_0);
                     if (fill_cnt != '0) begin
                        // First word issues on accept; FILL covers the remaining cnt words.
                        wr      = 1'b1;
                        addr_d  = ptr_q;
                        ptr_d   = ptr_q + ADDR_W'(1);
                        cnt_d   = fill_cnt - CNT_W'(1);
                        state_d = ST_FILL;
                     end else begin
                        rsp_d = ptr_word;
                     end
                  end
                  OP_GET_PTR: rsp_d = ptr_word;
                  default:    rsp_d = '0;
               endcase
            end
         end
         ST_FILL: begin
            if (cnt_q != '0) begin
               wr     = 1'b1;
               addr_d = ptr_q;
               ptr_d  = ptr_q + ADDR_W'(1);
               cnt_d  = cnt_q - CNT_W'(1);
            end else begin
               rsp_d   = ptr_word;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         bank_q  <= '0;
         cnt_q   <= '0;
         rsp_q   <= '0;
         addr_q  <= '0;
         dout_q  <= '0;
         we_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         bank_q  <= bank_d;
         cnt_q   <= cnt_d;
         rsp_q   <= rsp_d;
         addr_q  <= addr_d;
         dout_q  <= dout_d;
         we_q    <= we_d;
      end
   end

   assign cmd_ready             = (state_q == ST_IDLE);
   assign rsp_valid             = (state_q == ST_RESP);
   assign rsp_payload_outputs_0 = rsp_q;

   // Address and data are broadcast; only the strobe selects the bank.
   assign port0_addr = addr_q;
   assign port1_addr = addr_q;
   assign port2_addr = addr_q;
   assign port3_addr = addr_q;
   assign port0_dout = dout_q;
   assign port1_dout = dout_q;
   assign port2_dout = dout_q;
   assign port3_dout = dout_q;
   assign port0_we   = we_q[0];
   assign port1_we   = we_q[1];
   assign port2_we   = we_q[2];
   assign port3_we   = we_q[3];

endmodule

// File: tb/tb_mport_writer.sv
// Directed bench for mport_writer: pointer ops, writes, fills, wrap, saturation, reset mid-fill.
module tb_mport_writer;

   localparam int AW = 14;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [9:0]    fid = '0;
   logic [31:0]   in0 = '0;
   logic [31:0]   in1 = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [31:0]   rsp_data;
   logic [AW-1:0] a0, a1, a2, a3;
   logic [31:0]   d0, d1, d2, d3;
   logic          w0, w1, w2, w3;

   always #5 clk = ~clk;

   mport_writer dut (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .cmd_valid               (cmd_valid),
      .cmd_ready               (cmd_ready),
      .cmd_payload_function_id (fid),
      .cmd_payload_inputs_0    (in0),
      .cmd_payload_inputs_1    (in1),
      .rsp_valid               (rsp_valid),
      .rsp_ready               (rsp_ready),
      .rsp_payload_outputs_0   (rsp_data),
      .port0_addr (a0), .port0_dout (d0), .port0_we (w0),
      .port1_addr (a1), .port1_dout (d1), .port1_we (w1),
      .port2_addr (a2), .port2_dout (d2), .port2_we (w2),
      .port3_addr (a3), .port3_dout (d3), .port3_we (w3)
   );

   typedef struct {
      int            cy;
      int            port;
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } rec_t;

   rec_t wq[$];
   int   cyc = 0;
   int   acc = 0;
   int   passes = 0;
   int   checks = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (w0) wq.push_back('{cyc, 0, a0, d0});
      if (w1) wq.push_back('{cyc, 1, a1, d1});
      if (w2) wq.push_back('{cyc, 2, a2, d2});
      if (w3) wq.push_back('{cyc, 3, a3, d3});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int n;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      fid       = {7'h55, op};
      in0       = a;
      in1       = b;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      acc       = cyc;
   endtask

   task automatic wait_rsp(output logic [31:0] data, output int at, output int hi);
      int n;
      n = 0; hi = 0; at = -1; data = '0;
      while (n < 20000) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) break;
         if (cmd_ready === 1'b1) hi++;
         n++;
      end
      chk("rsp_timeout", 32'(rsp_valid), 32'd1);
      at   = cyc;
      data = rsp_data;
   endtask

   task automatic ack();
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      int          at, hi, bad;
      rec_t        r;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_we", 32'({w3, w2, w1, w0}), 32'd0);
      chk("rst_addr", 32'(a0), 32'd0);
      chk("rst_dout", d0, 32'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      issue(3'd3, 0, 0); wait_rsp(d, at, hi); ack();
      chk("get0_data", d, 32'h0);
      chk("get0_lat", 32'(at - acc), 32'd0);
      chk("get0_no_we", 32'(wq.size()), 32'd0);

      issue(3'd0, 32'd2, 32'h0100); wait_rsp(d, at, hi); ack();
      chk("set_rsp", d, 32'h0);
      wq.delete();
      issue(3'd1, 32'hDEADBEEF, 0); wait_rsp(d, at, hi); ack();
      chk("wr_rsp", d, 32'h100);
      chk("wr_lat", 32'(at - acc), 32'd0);
      chk("wr_count", 32'(wq.size()), 32'd1);
      if (wq.size() > 0) begin
         r = wq[0];
         chk("wr_port", 32'(r.port), 32'd2);
         chk("wr_addr", 32'(r.addr), 32'h100);
         chk("wr_data", r.data, 32'hDEADBEEF);
         chk("wr_cyc", 32'(r.cy - acc), 32'd0);
      end
      issue(3'd3, 0, 0); wait_rsp(d, at, hi); ack();
      chk("get_after_wr", d, 32'h8101);

      issue(3'd0, 32'd1, 32'h3FFE); wait_rsp(d, at, hi); ack();
      wq.delete();
      issue(3'd2, 32'h5A5A5A5A, 32'd4); wait_rsp(d, at, hi);
      chk("fill4_rsp", d, 32'h4002);
      chk("fill4_lat", 32'(at - acc), 32'd4);
      chk("fill4_ready_low", 32'(hi), 32'd0);
      chk("fill4_count", 32'(wq.size()), 32'd4);
      if (wq.size() == 4) begin
         bad = 0;
         for (int i = 0; i < 4; i++) begin
            r = wq[i];
            if (r.port != 1 || r.data != 32'h5A5A5A5A || r.cy != acc + i ||
                32'(r.addr) != ((32'h3FFE + i) & 32'h3FFF)) bad++;
         end
         chk("fill4_records", 32'(bad), 32'd0);
         chk("fill4_wrap_addr", 32'(wq[2].addr), 32'h0000);
      end
      ack();

      wq.delete();
      issue(3'd2, 32'h12345678, 32'd0); wait_rsp(d, at, hi);
      chk("fill0_lat", 32'(at - acc), 32'd0);
      chk("fill0_rsp", d, 32'h4002);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_valid", 32'(rsp_valid), 32'd1);
         chk("hold_data", rsp_data, 32'h4002);
         chk("hold_ready", 32'(cmd_ready), 32'd0);
      end
      ack();
      chk("fill0_no_we", 32'(wq.size()), 32'd0);

      issue(3'd0, 32'd3, 32'h1234); wait_rsp(d, at, hi); ack();
      wq.delete();
      issue(3'd2, 32'h77, 32'hFFFF_FFFF); wait_rsp(d, at, hi);
      chk("sat_rsp", d, 32'hD234);
      chk("sat_lat", 32'(at - acc), 32'd16384);
      chk("sat_count", 32'(wq.size()), 32'd16384);
      bad = 0;
      foreach (wq[i]) begin
         if (wq[i].port != 3 || wq[i].data != 32'h77 || wq[i].cy != acc + i ||
             32'(wq[i].addr) != ((32'h1234 + i) & 32'h3FFF)) bad++;
      end
      chk("sat_records", 32'(bad), 32'd0);
      ack();

      issue(3'd0, 32'd0, 32'h10); wait_rsp(d, at, hi); ack();
      issue(3'd2, 32'hCAFE, 32'd100);
      repeat (10) @(posedge clk);
      #2;
      chk("midfill_we_on", 32'(w0), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("midfill_we_off", 32'({w3, w2, w1, w0}), 32'd0);
      wq.delete();
      repeat (3) @(posedge clk);
      #1;
      chk("midfill_no_writes", 32'(wq.size()), 32'd0);
      reset_n = 1'b1;
      issue(3'd3, 0, 0); wait_rsp(d, at, hi); ack();
      chk("midfill_get", d, 32'h0);
      chk("midfill_no_writes_after", 32'(wq.size()), 32'd0);

      issue(3'd0, 32'd4, 32'd0); wait_rsp(d, at, hi); ack();
      wq.delete();
      issue(3'd1, 32'h1, 0); wait_rsp(d, at, hi); ack();
`ifdef MPORT_WRITER_BROADCAST_EN
      chk("bcast_count", 32'(wq.size()), 32'd4);
      bad = 0;
      foreach (wq[i]) if (wq[i].cy != acc || wq[i].addr != '0 || wq[i].data != 32'h1) bad++;
      chk("bcast_records", 32'(bad), 32'd0);
      issue(3'd3, 0, 0); wait_rsp(d, at, hi); ack();
      chk("bcast_get", d, 32'h10001);
`else
      chk("bank4_count", 32'(wq.size()), 32'd1);
      if (wq.size() > 0) begin
         chk("bank4_port", 32'(wq[0].port), 32'd0);
         chk("bank4_data", wq[0].data, 32'h1);
      end
      issue(3'd3, 0, 0); wait_rsp(d, at, hi); ack();
      chk("bank4_get", d, 32'h1);
`endif

      issue(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_rsp(d, at, hi); ack();
      chk("op6_rsp", d, 32'h0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
